// File: rtl/instr_sched.sv
// instr_sched: round-robin write-port arbiter and in-order occupancy controller for the 32-entry
// instruction register. Optional divide-by-zero guard is enabled by defining SCHED_DIV_GUARD_EN.
package instr_sched_pkg;
   typedef logic [2:0] opcode_t;
   typedef logic [7:0] operand_t;
   typedef struct packed {
      opcode_t  opcode;
      operand_t operand_a;
      operand_t operand_b;
      operand_t result;
   } instruction_t;
   localparam opcode_t OP_ADD = 3'd0;
   localparam opcode_t OP_SUB = 3'd1;
   localparam opcode_t OP_AND = 3'd2;
   localparam opcode_t OP_OR  = 3'd3;
   localparam opcode_t OP_XOR = 3'd4;
   localparam opcode_t OP_MUL = 3'd5;
   localparam opcode_t OP_DIV = 3'd6;
   localparam opcode_t OP_MOD = 3'd7;
endpackage

module instr_sched
   import instr_sched_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int SRC_W  = $clog2(NREQ)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  opcode_t  [NREQ-1:0]        req_opcode,
   input  operand_t [NREQ-1:0]        req_operand_a,
   input  operand_t [NREQ-1:0]        req_operand_b,
   output logic                       load_en,
   output opcode_t                    opcode,
   output operand_t                   operand_a,
   output operand_t                   operand_b,
   output logic [ADDR_W-1:0]          write_pointer,
   output logic [ADDR_W-1:0]          read_pointer,
   input  instruction_t               instruction_word,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output instruction_t               rsp_word,
   output logic [SRC_W-1:0]           rsp_src,
   output logic [ADDR_W:0]            count,
   output logic                       full,
   output logic                       empty,
   output logic                       err_valid,
   output logic [SRC_W-1:0]           err_src
);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wp_q, wp_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [SRC_W-1:0]  prio_q, prio_d, winner, cand;
   logic              load_en_q, load_en_d;
   opcode_t           opcode_q, opcode_d;
   operand_t          a_q, a_d, b_q, b_d;
   logic [SRC_W-1:0]  tag_q [DEPTH];
   logic [SRC_W-1:0]  tag_d [DEPTH];
   logic              found, accept, write, pop, div_zero;

   function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
      return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin search: first valid requester at or after the priority index.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = SRC_W'((int'(prio_q) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (found && !full) req_ready[winner] = 1'b1;
   end

   assign accept = found && !full;
   assign write  = accept && !div_zero;

   // The entry whose write is still in flight is not yet readable from the register.
   assign rsp_valid = (count_q - {{ADDR_W{1'b0}}, load_en_q}) != '0;
   assign pop       = rsp_valid && rsp_ready;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      prio_d    = prio_q;
      load_en_d = 1'b0;
      wp_d      = wp_q;
      opcode_d  = opcode_q;
      a_d       = a_q;
      b_d       = b_q;
      tag_d     = tag_q;
      if (accept) prio_d = (winner == SRC_W'(NREQ - 1)) ? '0 : winner + 1'b1;
      if (write) begin
         load_en_d       = 1'b1;
         wp_d            = wr_ptr_q;
         opcode_d        = req_opcode[winner];
         a_d             = req_operand_a[winner];
         b_d             = req_operand_b[winner];
         tag_d[wr_ptr_q] = winner;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({write, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         prio_q    <= '0;
         load_en_q <= 1'b0;
         wp_q      <= '0;
         opcode_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         prio_q    <= prio_d;
         load_en_q <= load_en_d;
         wp_q      <= wp_d;
         opcode_q  <= opcode_d;
         a_q       <= a_d;
         b_q       <= b_d;
         tag_q     <= tag_d;
      end
   end

`ifdef SCHED_DIV_GUARD_EN
   logic             err_valid_q, err_valid_d;
   logic [SRC_W-1:0] err_src_q, err_src_d;

   // A zero divisor still consumes the grant but never reaches the register.
   assign div_zero = ((req_opcode[winner] == OP_DIV) || (req_opcode[winner] == OP_MOD))
                     && (req_operand_b[winner] == '0);

   always_comb begin
      err_valid_d = accept && div_zero;
      err_src_d   = (accept && div_zero) ? winner : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_valid_q <= 1'b0;
         err_src_q   <= '0;
      end else begin
         err_valid_q <= err_valid_d;
         err_src_q   <= err_src_d;
      end
   end

   assign err_valid = err_valid_q;
   assign err_src   = err_src_q;
`else
   assign div_zero  = 1'b0;
   assign err_valid = 1'b0;
   assign err_src   = '0;
`endif

   assign load_en       = load_en_q;
   assign opcode        = opcode_q;
   assign operand_a     = a_q;
   assign operand_b     = b_q;
   assign write_pointer = wp_q;
   assign read_pointer  = rd_ptr_q;
   assign rsp_word      = instruction_word;
   assign rsp_src       = tag_q[rd_ptr_q];
   assign count         = count_q;
   assign full          = count_q == (ADDR_W + 1)'(DEPTH);
   assign empty         = count_q == '0;

endmodule

// File: tb/tb_instr_sched.sv
// Randomized scoreboard bench for instr_sched with a behavioural queue model and an
// instruction-register model that computes the result word on read.
module tb_instr_sched;
   import instr_sched_pkg::*;

   localparam int NREQ   = 4;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;
   localparam int SRC_W  = 2;
`ifdef SCHED_DIV_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct packed {
      logic [SRC_W-1:0] src;
      instruction_t     word;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [NREQ-1:0]       req_valid, req_ready;
   opcode_t  [NREQ-1:0]   req_opcode;
   operand_t [NREQ-1:0]   req_operand_a, req_operand_b;
   logic                  load_en;
   opcode_t               opcode;
   operand_t              operand_a, operand_b;
   logic [ADDR_W-1:0]     write_pointer, read_pointer;
   instruction_t          instruction_word, rsp_word;
   logic                  rsp_valid, rsp_ready;
   logic [SRC_W-1:0]      rsp_src, err_src;
   logic [ADDR_W:0]       count;
   logic                  full, empty, err_valid;

   int checks = 0;
   int errors = 0;

   logic [NREQ-1:0] refill;
   int              valid_pct, ready_pct;
   bit              allow_div0;

   always #5 clk = ~clk;

   instr_sched #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
      .load_en(load_en), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .write_pointer(write_pointer), .read_pointer(read_pointer),
      .instruction_word(instruction_word),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word), .rsp_src(rsp_src),
      .count(count), .full(full), .empty(empty), .err_valid(err_valid), .err_src(err_src)
   );

   function automatic operand_t ref_result(input opcode_t op, input operand_t a, input operand_t b);
      if (op == OP_ADD) return a + b;
      if (op == OP_SUB) return a - b;
      if (op == OP_AND) return a & b;
      if (op == OP_OR)  return a | b;
      if (op == OP_XOR) return a ^ b;
      if (op == OP_MUL) return a * b;
      if (b == 8'd0)    return 8'd0;
      if (op == OP_DIV) return a / b;
      return a % b;
   endfunction

   // Instruction register: written on load_en, read combinationally with the result computed.
   opcode_t  mem_op [DEPTH];
   operand_t mem_a  [DEPTH];
   operand_t mem_b  [DEPTH];

   always @(posedge clk) begin
      if (load_en) begin
         mem_op[write_pointer] <= opcode;
         mem_a[write_pointer]  <= operand_a;
         mem_b[write_pointer]  <= operand_b;
      end
   end

   always_comb begin
      instruction_word.opcode    = mem_op[read_pointer];
      instruction_word.operand_a = mem_a[read_pointer];
      instruction_word.operand_b = mem_b[read_pointer];
      instruction_word.result    = ref_result(mem_op[read_pointer], mem_a[read_pointer], mem_b[read_pointer]);
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: accepted entries in a queue, round-robin priority as a plain integer.
   exp_t             sb [$];
   int               m_prio, m_wr, m_rd, m_wp_last, m_err_src;
   bit               m_inflight, m_err;

   always @(negedge clk) begin
      int               exp_win, vis;
      logic [NREQ-1:0]  exp_ready;
      logic [SRC_W-1:0] ix;
      exp_t             e;
      if (!reset_n) begin
         sb.delete();
         m_prio = 0; m_wr = 0; m_rd = 0; m_wp_last = 0; m_err_src = 0;
         m_inflight = 1'b0; m_err = 1'b0;
      end else begin
         exp_win   = -1;
         exp_ready = '0;
         if (sb.size() < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
               ix = SRC_W'((m_prio + k) % NREQ);
               if (exp_win < 0 && req_valid[ix]) exp_win = (m_prio + k) % NREQ;
            end
         end
         if (exp_win >= 0) exp_ready = NREQ'(1) << exp_win;
         check_output("req_ready", 32'(req_ready), 32'(exp_ready));
         check_output("count", 32'(count), sb.size());
         check_output("full", 32'(full), 32'(sb.size() == DEPTH));
         check_output("empty", 32'(empty), 32'(sb.size() == 0));
         check_output("load_en", 32'(load_en), 32'(m_inflight));
         if (m_inflight) check_output("write_pointer", 32'(write_pointer), m_wp_last);
         check_output("read_pointer", 32'(read_pointer), m_rd);
         check_output("err_valid", 32'(err_valid), 32'(m_err));
         if (m_err) check_output("err_src", 32'(err_src), m_err_src);
         vis = sb.size() - int'(m_inflight);
         check_output("rsp_valid", 32'(rsp_valid), 32'(vis > 0));
         if (vis > 0) begin
            check_output("rsp_word", 32'(rsp_word), 32'(sb[0].word));
            check_output("rsp_src", 32'(rsp_src), 32'(sb[0].src));
            if (rsp_ready) begin
               void'(sb.pop_front());
               m_rd = (m_rd + 1) % DEPTH;
            end
         end
         m_inflight = 1'b0;
         m_err      = 1'b0;
         if (exp_win >= 0) begin
            ix     = SRC_W'(exp_win);
            m_prio = (exp_win + 1) % NREQ;
            if (GUARD && (req_opcode[ix] == OP_DIV || req_opcode[ix] == OP_MOD) && req_operand_b[ix] == 8'd0) begin
               m_err     = 1'b1;
               m_err_src = exp_win;
            end else begin
               e.src            = ix;
               e.word.opcode    = req_opcode[ix];
               e.word.operand_a = req_operand_a[ix];
               e.word.operand_b = req_operand_b[ix];
               e.word.result    = ref_result(req_opcode[ix], req_operand_a[ix], req_operand_b[ix]);
               sb.push_back(e);
               m_wp_last  = m_wr;
               m_wr       = (m_wr + 1) % DEPTH;
               m_inflight = 1'b1;
            end
         end
      end
   end

   task automatic new_req(input logic [SRC_W-1:0] ix);
      req_valid[ix]     = 1'b1;
      req_opcode[ix]    = opcode_t'($urandom_range(7));
      req_operand_a[ix] = operand_t'($urandom);
      if (allow_div0 && $urandom_range(3) == 0) req_operand_b[ix] = 8'd0;
      else                                      req_operand_b[ix] = operand_t'($urandom_range(255, 1));
   endtask

   task automatic set_req(input logic [SRC_W-1:0] ix, input opcode_t op, input operand_t a, input operand_t b);
      req_valid[ix]     = 1'b1;
      req_opcode[ix]    = op;
      req_operand_a[ix] = a;
      req_operand_b[ix] = b;
   endtask

   // One clock: requesters that were granted drop or reload, then rsp_ready is redrawn.
   task automatic apply_stimulus();
      logic [NREQ-1:0]  acc;
      logic [SRC_W-1:0] ix;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         ix = SRC_W'(i);
         if (acc[ix]) req_valid[ix] = 1'b0;
         if (!req_valid[ix] && refill[ix] && int'($urandom_range(99)) < valid_pct) new_req(ix);
      end
      if (ready_pct >= 0) rsp_ready = int'($urandom_range(99)) < ready_pct;
   endtask

   task automatic drain();
      int n;
      n         = 0;
      refill    = '0;
      ready_pct = 100;
      while (n < 300 && !(req_valid == '0 && empty && !load_en)) begin
         apply_stimulus();
         n++;
      end
      check_output("drain_empty", 32'(empty), 32'd1);
   endtask

   task automatic do_reset();
      req_valid = '0;
      reset_n   = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [ADDR_W-1:0] rp, wp;
      int n;
      reset_n = 1'b0; req_valid = '0; req_opcode = '0; req_operand_a = '0; req_operand_b = '0;
      rsp_ready = 1'b0; refill = '0; valid_pct = 0; ready_pct = 100; allow_div0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_count", 32'(count), 32'd0);
      check_output("reset_empty", 32'(empty), 32'd1);
      check_output("reset_full", 32'(full), 32'd0);
      check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      reset_n   = 1'b1;
      rsp_ready = 1'b1;

      $display("[TB] single request from requester 2");
      set_req(2'd2, OP_ADD, 8'd5, 8'd3);
      #1;
      check_output("single_ready", 32'(req_ready), 32'b0100);
      apply_stimulus();
      check_output("single_load_en", 32'(load_en), 32'd1);
      check_output("single_wp", 32'(write_pointer), 32'd0);
      check_output("single_not_yet", 32'(rsp_valid), 32'd0);
      apply_stimulus();
      check_output("single_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("single_result", 32'(rsp_word.result), 32'd8);
      check_output("single_src", 32'(rsp_src), 32'd2);

      $display("[TB] fairness with all requesters valid");
      refill = '1; valid_pct = 100;
      for (int i = 0; i < NREQ; i++) new_req(SRC_W'(i));
      repeat (40) apply_stimulus();
      drain();

      $display("[TB] divide by zero");
      set_req(2'd1, OP_DIV, 8'd10, 8'd0);
      apply_stimulus();
      check_output("div0_err_valid", 32'(err_valid), 32'(GUARD));
      check_output("div0_err_src", 32'(err_src), GUARD ? 32'd1 : 32'd0);
      check_output("div0_load_en", 32'(load_en), 32'(!GUARD));
      set_req(2'd1, OP_DIV, 8'd10, 8'd2);
      apply_stimulus();
      apply_stimulus();
      check_output("div_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("div_result", 32'(rsp_word.result), 32'd5);
      drain();

      $display("[TB] fill and wrap");
      do_reset();
      refill = '1; valid_pct = 100; ready_pct = 0; rsp_ready = 1'b0;
      n = 0;
      while (n < 200 && !full) begin apply_stimulus(); n++; end
      check_output("fill_full", 32'(full), 32'd1);
      check_output("fill_count", 32'(count), 32'd32);
      repeat (2) apply_stimulus();
      #1;
      check_output("fill_no_grant", 32'(req_ready), 32'd0);
      ready_pct = -1; rsp_ready = 1'b1;
      apply_stimulus();
      rsp_ready = 1'b0;
      apply_stimulus();
      check_output("wrap_load_en", 32'(load_en), 32'd1);
      check_output("wrap_wp", 32'(write_pointer), 32'd0);
      check_output("wrap_count", 32'(count), 32'd32);
      req_valid = '0;
      drain();

      $display("[TB] simultaneous accept and pop");
      allow_div0 = 1'b0; refill = 4'b0001; valid_pct = 100; ready_pct = 0;
      n = 0;
      while (n < 20 && count != 6'd5) begin apply_stimulus(); n++; end
      check_output("sim_count5", 32'(count), 32'd5);
      rp = read_pointer; wp = write_pointer;
      ready_pct = -1; rsp_ready = 1'b1;
      apply_stimulus();
      check_output("sim_count", 32'(count), 32'd5);
      check_output("sim_rp", 32'(read_pointer), 32'(ADDR_W'(rp + 1'b1)));
      check_output("sim_wp", 32'(write_pointer), 32'(ADDR_W'(wp + 1'b1)));

      $display("[TB] reset during operation");
      ready_pct = 0;
      n = 0;
      while (n < 20 && count != 6'd7) begin apply_stimulus(); n++; end
      check_output("mid_count7", 32'(count), 32'd7);
      check_output("mid_load_en", 32'(load_en), 32'd1);
      refill = '0; req_valid = '0;
      #1 reset_n = 1'b0;
      #1;
      check_output("mid_rst_load_en", 32'(load_en), 32'd0);
      check_output("mid_rst_count", 32'(count), 32'd0);
      check_output("mid_rst_empty", 32'(empty), 32'd1);
      check_output("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("mid_rst_rp", 32'(read_pointer), 32'd0);
      check_output("mid_rst_wp", 32'(write_pointer), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      set_req(2'd3, OP_SUB, 8'd9, 8'd4);
      apply_stimulus();
      check_output("post_rst_load_en", 32'(load_en), 32'd1);
      check_output("post_rst_wp", 32'(write_pointer), 32'd0);
      drain();

      $display("[TB] random traffic");
      allow_div0 = 1'b1; refill = '1; valid_pct = 60; ready_pct = 50;
      repeat (300) apply_stimulus();
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_sched.md
# instr_sched

Round-robin scheduler and occupancy controller for the 32-entry instruction register. It arbitrates up to NREQ requesters competing for the single write port and allocates write slots in order. It drives the register's load and write-pointer inputs, then drains the stored instruction words (operands plus computed result) through a valid/ready response port, so the register behaves as an in-order queue.

## Interface
- NREQ, 4, number of requesters (2..8)
- DEPTH, 32, register entries; must equal register depth
- ADDR_W, 5, pointer width, $clog2(DEPTH)
- SRC_W, 2, source-id width, $clog2(NREQ)

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester instruction valid
- req_ready  out  NREQ  per-requester grant; one-hot or zero
- req_opcode  in  NREQ x opcode_t  per-requester opcode
- req_operand_a, req_operand_b  in  NREQ x operand_t  per-requester operands
- load_en  out  1  to register write enable
- opcode, operand_a, operand_b  out  opcode_t/operand_t  to register write data
- write_pointer, read_pointer  out  ADDR_W  to register
- instruction_word  in  instruction_t  from register, combinational read
- rsp_valid  out  1  head entry available
- rsp_ready  in  1  consumer pops head
- rsp_word  out  instruction_t  equals instruction_word
- rsp_src  out  SRC_W  requester id of the head entry
- count  out  ADDR_W+1  allocated entries, 0..DEPTH
- full, empty  out  1  count==DEPTH / count==0
- err_valid  out  1  one-cycle pulse, rejected request
- err_src  out  SRC_W  requester id of the rejected request

## Operation
- Reset: wr_ptr=rd_ptr=0, count=0, load_en=0, write/read_pointer=0, rr priority=0, rsp_valid=0, err_valid=0, tag memory cleared, empty=1, full=0.
- Arbitration: combinational round-robin over req_valid, starting at the priority index. req_ready[i]=1 only for the winner and only when !full. Accept means req_valid[i]&req_ready[i]. After an accept, priority moves to winner+1 mod NREQ. With no accept, priority holds.
- On accept at edge t: register opcode, operands, write_pointer<=wr_ptr, and load_en<=1 for cycle t+1. Store the source id into tag[wr_ptr]. Advance wr_ptr mod DEPTH. load_en returns to 0 in the next cycle unless another accept occurs; back-to-back accepts sustain 1 write per cycle.
- Occupancy: count +1 on accept, -1 on pop, unchanged on simultaneous accept and pop.
- Read side: read_pointer=rd_ptr, registered. rsp_valid = (count - load_en) > 0, so the entry whose write is still in flight is excluded. rsp_word=instruction_word, rsp_src=tag[rd_ptr].
- Pop on rsp_valid&rsp_ready: rd_ptr advances mod DEPTH.
- Pointers wrap DEPTH-1 -> 0 without gaps.
- Full: all req_ready=0, and requests are held by the requester. A pop while full frees a slot the next cycle.
- Reset mid-operation clears all state immediately; in-flight load_en drops asynchronously.

## Timing
- Accept at edge t → load_en high during t+1 → register written at edge t+1 → rsp_valid earliest in cycle t+2. Accept-to-response latency is 2 cycles.
- Throughput: 1 accept and 1 pop per cycle.
- req_ready depends combinationally on req_valid and full; it has no dependency on rsp_ready.
- rsp_word is combinational from the register through the registered read_pointer.

## Configuration
- SCHED_DIV_GUARD_EN defined: a DIV or MOD request with operand_b==0 is still accepted (consumes a grant and advances priority) but is not written.
  - load_en stays 0, and wr_ptr and count are unchanged.
  - err_valid pulses for 1 cycle after the accept edge, with err_src = requester id.
- SCHED_DIV_GUARD_EN undefined: such requests are written normally. err_valid and err_src are tied to 0.

## Test plan
- Reset, then a single request: requester 2 sends ADD a=5 b=3 → req_ready[2] in the same cycle; load_en and write_pointer=0 next cycle; rsp_valid 2 cycles after the accept, with result=8 and rsp_src=2.
- Fairness: all 4 requesters hold valid, rsp_ready=1 → grant order 0,1,2,3,0,… with exactly one grant per cycle.
- Fill and wrap: 32 accepts with rsp_ready=0 → full=1, count=32, all req_ready=0. Pop one → one more accept at write_pointer=0. Drain 32 → entries return in write order and empty=1.
- Simultaneous accept and pop at count=5 → count stays 5 and both pointers advance.
- Reset asserted while load_en=1 and count=7 → outputs reach their reset values without a clock; the following request lands at pointer 0.
- With SCHED_DIV_GUARD_EN: DIV a=10 b=0 from requester 1 → err_valid pulse with err_src=1, no load_en, count unchanged. Then DIV a=10 b=2 → written with result=5.
